// File: rtl/vdp_cpu_port.sv
// CPU-side front end of the VDP. It decodes Z80 data/control port accesses into
// VRAM/CRAM/register-file writes, buffered VRAM reads and status reads.
module vdp_cpu_port #(
    parameter int RD_LAT   = 2,
    parameter int NUM_REGS = 10
) (
    input  logic                  clk,
    input  logic                  rst_L,
    input  logic                  cpu_wr,
    input  logic                  cpu_rd,
    input  logic                  cpu_port_sel,
    input  logic [7:0]            cpu_data_in,
    output logic [7:0]            cpu_data_out,
    output logic                  cpu_wait,
    input  logic                  screenBusy,
    output logic [13:0]           VRAM_addr,
    output logic                  VRAM_wr_en,
    output logic [7:0]            VRAM_wr_data,
    output logic                  VRAM_rd_en,
    input  logic [7:0]            VRAM_rd_data,
    output logic                  CRAM_wr_en,
    output logic [4:0]            CRAM_addr,
    output logic [5:0]            CRAM_wr_data,
    output logic [NUM_REGS*8-1:0] regFile,
    input  logic                  frame_set,
    input  logic                  sprOvf_set,
    input  logic                  sprColl_set,
    output logic                  irq_L
);

    localparam int CW = $clog2(RD_LAT + 1);

    typedef enum logic [2:0] {IDLE, WAIT_BUS, WRITE, RD_ISSUE, RD_WAIT} state_t;

    state_t        state, state_nx;
    logic [13:0]   addr;
    logic [1:0]    code;
    logic [7:0]    latch;
    logic          first_done;
    logic [7:0]    rd_buf;
    logic [2:0]    status;
    logic [13:0]   mem_addr;
    logic [7:0]    mem_data;
    logic          mem_is_rd;
    logic          mem_is_cram;
    logic [CW-1:0] lat_cnt;
    logic [7:0]    data_out_q;
    logic          irq_q;
    logic [7:0]    regs [NUM_REGS];

    // Strobes are only honoured in IDLE; anything else is a protocol violation.
    logic idle, ctrl_wr, data_wr, ctrl_rd, data_rd, prefetch, start_mem, capture;

    assign idle      = (state == IDLE);
    assign ctrl_wr   = idle & cpu_wr & cpu_port_sel;
    assign data_wr   = idle & cpu_wr & ~cpu_port_sel;
    assign ctrl_rd   = idle & cpu_rd & ~cpu_wr & cpu_port_sel;
    assign data_rd   = idle & cpu_rd & ~cpu_wr & ~cpu_port_sel;
    assign prefetch  = ctrl_wr & first_done & (cpu_data_in[7:6] == 2'b00);
    assign start_mem = data_wr | data_rd | prefetch;
    assign capture   = (state == RD_WAIT) && (lat_cnt == CW'(RD_LAT));

    always_ff @(posedge clk) begin
        if (!rst_L) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx   = state;
        cpu_wait   = 1'b1;
        VRAM_wr_en = 1'b0;
        CRAM_wr_en = 1'b0;
        VRAM_rd_en = 1'b0;
        case (state)
            IDLE: begin
                cpu_wait = 1'b0;
                if (start_mem) state_nx = WAIT_BUS;
            end
            WAIT_BUS: begin
                if (!screenBusy) state_nx = mem_is_rd ? RD_ISSUE : WRITE;
            end
            WRITE: begin
                VRAM_wr_en = ~mem_is_cram;
                CRAM_wr_en = mem_is_cram;
                state_nx   = IDLE;
            end
            RD_ISSUE: begin
                VRAM_rd_en = 1'b1;
                state_nx   = RD_WAIT;
            end
            RD_WAIT: begin
                if (capture) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // The access address/data are snapshotted at the strobe so the post-access
    // increment of addr never disturbs the bus while a transfer is in flight.
    always_ff @(posedge clk) begin
        if (!rst_L) begin
            addr        <= '0;
            code        <= '0;
            latch       <= '0;
            first_done  <= 1'b0;
            rd_buf      <= '0;
            status      <= '0;
            mem_addr    <= '0;
            mem_data    <= '0;
            mem_is_rd   <= 1'b0;
            mem_is_cram <= 1'b0;
            lat_cnt     <= '0;
            data_out_q  <= '0;
            irq_q       <= 1'b1;
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
        end else begin
            status <= (ctrl_rd ? 3'b000 : status) | {frame_set, sprOvf_set, sprColl_set};
            irq_q  <= ~(status[2] & regs[1][5]);

            if (data_wr | data_rd | ctrl_rd) first_done <= 1'b0;

            if (ctrl_wr) begin
                if (!first_done) begin
                    latch      <= cpu_data_in;
                    addr[7:0]  <= cpu_data_in;
                    first_done <= 1'b1;
                end else begin
                    code       <= cpu_data_in[7:6];
                    addr[13:8] <= cpu_data_in[5:0];
                    first_done <= 1'b0;
                    if (cpu_data_in[7:6] == 2'b10) begin
                        for (int i = 0; i < NUM_REGS; i++)
                            if (cpu_data_in[3:0] == 4'(i)) regs[i] <= latch;
                    end
                end
            end

            if (data_rd) data_out_q <= rd_buf;
            if (ctrl_rd) data_out_q <= {status, 5'b00000};

            if (start_mem) begin
                mem_addr    <= prefetch ? {cpu_data_in[5:0], addr[7:0]} : addr;
                mem_data    <= cpu_data_in;
                mem_is_rd   <= ~data_wr;
                mem_is_cram <= data_wr & (code == 2'b11);
            end

            if (state == RD_ISSUE)     lat_cnt <= CW'(1);
            else if (state == RD_WAIT) lat_cnt <= lat_cnt + CW'(1);

            if (state == WRITE) begin
                rd_buf <= mem_data;
                addr   <= addr + 14'd1;
            end
            if (capture) begin
                rd_buf <= VRAM_rd_data;
                addr   <= addr + 14'd1;
            end
        end
    end

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_reg_out
        assign regFile[g*8 +: 8] = regs[g];
    end

    assign cpu_data_out = data_out_q;
    assign irq_L        = irq_q;
    assign VRAM_addr    = mem_addr;
    assign VRAM_wr_data = mem_data;
    assign CRAM_addr    = mem_addr[4:0];
    assign CRAM_wr_data = mem_data[5:0];

endmodule

// File: tb/tb_vdp_cpu_port.sv
// Self-checking bench for vdp_cpu_port: table-driven register writes plus
// directed sequences for VRAM/CRAM writes, reads, bus stalls and status/irq.
module tb_vdp_cpu_port;

    localparam int NUM_REGS = 10;

    logic                  clk = 1'b0;
    logic                  rst_L = 1'b0;
    logic                  cpu_wr = 1'b0;
    logic                  cpu_rd = 1'b0;
    logic                  cpu_port_sel = 1'b0;
    logic [7:0]            cpu_data_in = 8'h00;
    logic [7:0]            cpu_data_out;
    logic                  cpu_wait;
    logic                  screenBusy = 1'b0;
    logic [13:0]           VRAM_addr;
    logic                  VRAM_wr_en;
    logic [7:0]            VRAM_wr_data;
    logic                  VRAM_rd_en;
    logic [7:0]            VRAM_rd_data;
    logic                  CRAM_wr_en;
    logic [4:0]            CRAM_addr;
    logic [5:0]            CRAM_wr_data;
    logic [NUM_REGS*8-1:0] regFile;
    logic                  frame_set = 1'b0;
    logic                  sprOvf_set = 1'b0;
    logic                  sprColl_set = 1'b0;
    logic                  irq_L;

    vdp_cpu_port #(.RD_LAT(2), .NUM_REGS(NUM_REGS)) dut (
        .clk(clk), .rst_L(rst_L), .cpu_wr(cpu_wr), .cpu_rd(cpu_rd),
        .cpu_port_sel(cpu_port_sel), .cpu_data_in(cpu_data_in),
        .cpu_data_out(cpu_data_out), .cpu_wait(cpu_wait), .screenBusy(screenBusy),
        .VRAM_addr(VRAM_addr), .VRAM_wr_en(VRAM_wr_en), .VRAM_wr_data(VRAM_wr_data),
        .VRAM_rd_en(VRAM_rd_en), .VRAM_rd_data(VRAM_rd_data),
        .CRAM_wr_en(CRAM_wr_en), .CRAM_addr(CRAM_addr), .CRAM_wr_data(CRAM_wr_data),
        .regFile(regFile), .frame_set(frame_set), .sprOvf_set(sprOvf_set),
        .sprColl_set(sprColl_set), .irq_L(irq_L)
    );

    always #5 clk = ~clk;

    // VRAM model: data is valid only in the cycle exactly two cycles after the request.
    logic [1:0] rd_sh = 2'b00;
    logic [7:0] vram_ret = 8'h00;
    always @(posedge clk) rd_sh <= {rd_sh[0], VRAM_rd_en};
    assign VRAM_rd_data = rd_sh[1] ? vram_ret : 8'hEE;

    int          wr_cnt = 0, cram_cnt = 0, rd_cnt = 0, wait_cnt = 0;
    logic [13:0] last_vaddr = '0, last_raddr = '0;
    logic [7:0]  last_vdata = '0;
    logic [4:0]  last_caddr = '0;
    logic [5:0]  last_cdata = '0;

    always @(negedge clk) begin
        if (VRAM_wr_en) begin
            wr_cnt     <= wr_cnt + 1;
            last_vaddr <= VRAM_addr;
            last_vdata <= VRAM_wr_data;
        end
        if (CRAM_wr_en) begin
            cram_cnt   <= cram_cnt + 1;
            last_caddr <= CRAM_addr;
            last_cdata <= CRAM_wr_data;
        end
        if (VRAM_rd_en) begin
            rd_cnt     <= rd_cnt + 1;
            last_raddr <= VRAM_addr;
        end
        if (cpu_wait) wait_cnt <= wait_cnt + 1;
    end

    int checks = 0;
    int failures = 0;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic wr, input logic sel, input logic [7:0] d);
        @(negedge clk);
        cpu_wr       = wr;
        cpu_rd       = ~wr;
        cpu_port_sel = sel;
        cpu_data_in  = d;
        @(negedge clk);
        cpu_wr = 1'b0;
        cpu_rd = 1'b0;
    endtask

    task automatic waitIdle(input string name);
        int n;
        n = 0;
        while (cpu_wait && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (cpu_wait) begin
            checks++;
            failures++;
            $display("[TB] FAIL %s: cpu_wait still 1 after 100 cycles, expected 0", name);
        end
    endtask

    typedef struct {
        logic [7:0] b1;
        logic [7:0] b2;
        int         idx;
        logic [7:0] val;
    } reg_vec_t;

    reg_vec_t              vecs[6];
    logic [7:0]            exp_regs[NUM_REGS];
    logic [NUM_REGS*8-1:0] exp_vec;
    int                    base_w, base_c, base_r, base_t, bad;

    initial begin
        vecs[0] = '{8'h07, 8'h81, 1,  8'h07};
        vecs[1] = '{8'h55, 8'h8C, 12, 8'h00};
        vecs[2] = '{8'hA5, 8'h80, 0,  8'hA5};
        vecs[3] = '{8'h3C, 8'h89, 9,  8'h3C};
        vecs[4] = '{8'h99, 8'h8A, 10, 8'h00};
        vecs[5] = '{8'h20, 8'h81, 1,  8'h20};
        for (int i = 0; i < NUM_REGS; i++) exp_regs[i] = 8'h00;

        repeat (3) @(negedge clk);
        checkOutput("rst_vram_addr", 32'(VRAM_addr), 32'h0);
        checkOutput("rst_enables", {29'd0, VRAM_wr_en, VRAM_rd_en, CRAM_wr_en}, 32'h0);
        checkOutput("rst_data_out", 32'(cpu_data_out), 32'h0);
        checkOutput("rst_wait", 32'(cpu_wait), 32'h0);
        checkOutput("rst_irq_L", 32'(irq_L), 32'h1);
        checkOutput("rst_regfile_lo", regFile[31:0], 32'h0);
        checkOutput("rst_cram", {21'd0, CRAM_addr, CRAM_wr_data}, 32'h0);
        rst_L = 1'b1;

        for (int v = 0; v < 6; v++) begin
            base_w = wr_cnt; base_c = cram_cnt; base_r = rd_cnt; base_t = wait_cnt;
            applyStimulus(1'b1, 1'b1, vecs[v].b1);
            applyStimulus(1'b1, 1'b1, vecs[v].b2);
            @(negedge clk);
            if (vecs[v].idx < NUM_REGS) exp_regs[vecs[v].idx] = vecs[v].val;
            for (int i = 0; i < NUM_REGS; i++) exp_vec[i*8 +: 8] = exp_regs[i];
            checkOutput($sformatf("regfile_vec%0d", v), regFile[31:0], exp_vec[31:0]);
            checkOutput($sformatf("regfile_hi_vec%0d", v), 32'(regFile[79:32]), 32'(exp_vec[79:32]));
            checkOutput($sformatf("no_access_vec%0d", v),
                        32'((wr_cnt - base_w) + (cram_cnt - base_c) + (rd_cnt - base_r) + (wait_cnt - base_t)), 32'h0);
        end

        // VRAM write at 0x1234 with exact cycle timing
        applyStimulus(1'b1, 1'b1, 8'h34);
        applyStimulus(1'b1, 1'b1, 8'h52);
        base_w = wr_cnt; base_t = wait_cnt;
        applyStimulus(1'b1, 1'b0, 8'hAB);
        checkOutput("wr_s1_wait", {30'd0, cpu_wait, VRAM_wr_en}, 32'h2);
        @(negedge clk);
        checkOutput("wr_s2_enable", {30'd0, cpu_wait, VRAM_wr_en}, 32'h3);
        checkOutput("wr_s2_addr", 32'(VRAM_addr), 32'h1234);
        checkOutput("wr_s2_data", 32'(VRAM_wr_data), 32'hAB);
        @(negedge clk);
        checkOutput("wr_s3_idle", {30'd0, cpu_wait, VRAM_wr_en}, 32'h0);
        checkOutput("wr_pulses", 32'(wr_cnt - base_w), 32'h1);
        checkOutput("wr_wait_cycles", 32'(wait_cnt - base_t), 32'h2);
        applyStimulus(1'b1, 1'b0, 8'hCD);
        waitIdle("wr2_idle");
        checkOutput("wr2_addr_inc", 32'(last_vaddr), 32'h1235);

        // Prefetch at 0x3FFF, address wraps, refill reads at 0x0000 then 0x0001
        vram_ret = 8'h11;
        applyStimulus(1'b1, 1'b1, 8'hFF);
        base_r = rd_cnt; base_t = wait_cnt;
        applyStimulus(1'b1, 1'b1, 8'h3F);
        waitIdle("pf_idle");
        checkOutput("pf_rd_pulses", 32'(rd_cnt - base_r), 32'h1);
        checkOutput("pf_rd_addr", 32'(last_raddr), 32'h3FFF);
        checkOutput("pf_wait_cycles", 32'(wait_cnt - base_t), 32'h4);
        vram_ret = 8'h22;
        applyStimulus(1'b0, 1'b0, 8'h00);
        checkOutput("rd1_data", 32'(cpu_data_out), 32'h11);
        waitIdle("rd1_idle");
        checkOutput("rd1_refill_addr", 32'(last_raddr), 32'h0000);
        vram_ret = 8'h33;
        applyStimulus(1'b0, 1'b0, 8'h00);
        checkOutput("rd2_data", 32'(cpu_data_out), 32'h22);
        waitIdle("rd2_idle");
        checkOutput("rd2_refill_addr", 32'(last_raddr), 32'h0001);

        // CRAM writes wrap 0x1F -> 0x00; written byte lands in the read buffer
        applyStimulus(1'b1, 1'b1, 8'h1F);
        applyStimulus(1'b1, 1'b1, 8'hC0);
        base_w = wr_cnt; base_c = cram_cnt;
        applyStimulus(1'b1, 1'b0, 8'h3C);
        waitIdle("cram1_idle");
        checkOutput("cram1_entry", {21'd0, last_caddr, last_cdata}, {21'd0, 5'h1F, 6'h3C});
        applyStimulus(1'b1, 1'b0, 8'h03);
        waitIdle("cram2_idle");
        checkOutput("cram2_entry", {21'd0, last_caddr, last_cdata}, {21'd0, 5'h00, 6'h03});
        checkOutput("cram_pulse_counts", {16'(wr_cnt - base_w), 16'(cram_cnt - base_c)}, {16'd0, 16'd2});
        applyStimulus(1'b0, 1'b0, 8'h00);
        checkOutput("cram_rdbuf", 32'(cpu_data_out), 32'h03);
        waitIdle("cram_rd_idle");

        // Write held off by screenBusy; a strobe during the stall is ignored
        applyStimulus(1'b1, 1'b1, 8'h00);
        applyStimulus(1'b1, 1'b1, 8'h40);
        screenBusy = 1'b1;
        applyStimulus(1'b1, 1'b0, 8'h5A);
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (VRAM_wr_en || CRAM_wr_en || !cpu_wait) bad++;
            cpu_wr       = (i == 5);
            cpu_port_sel = 1'b1;
            cpu_data_in  = 8'h77;
        end
        cpu_wr = 1'b0;
        checkOutput("busy_hold_violations", 32'(bad), 32'h0);
        screenBusy = 1'b0;
        @(negedge clk);
        checkOutput("busy_release_enable", 32'(VRAM_wr_en), 32'h1);
        checkOutput("busy_release_addr_data", {10'd0, VRAM_addr, VRAM_wr_data}, {10'd0, 14'h0000, 8'h5A});
        waitIdle("busy_idle");
        applyStimulus(1'b1, 1'b1, 8'h10);
        applyStimulus(1'b1, 1'b1, 8'h40);
        applyStimulus(1'b1, 1'b0, 8'h66);
        waitIdle("post_busy_idle");
        checkOutput("ignored_strobe_addr", 32'(last_vaddr), 32'h0010);

        // Status flags and frame interrupt (regFile[1] = 0x20 enables it)
        @(negedge clk); frame_set = 1'b1;
        @(negedge clk); frame_set = 1'b0;
        @(negedge clk);
        checkOutput("irq_asserted", 32'(irq_L), 32'h0);
        @(negedge clk);
        cpu_rd = 1'b1; cpu_port_sel = 1'b1; frame_set = 1'b1;
        @(negedge clk);
        cpu_rd = 1'b0; frame_set = 1'b0;
        checkOutput("status_read_coincident", 32'(cpu_data_out), 32'h80);
        applyStimulus(1'b0, 1'b1, 8'h00);
        checkOutput("status_set_wins", 32'(cpu_data_out), 32'h80);
        applyStimulus(1'b0, 1'b1, 8'h00);
        checkOutput("status_cleared", 32'(cpu_data_out), 32'h00);
        @(negedge clk);
        checkOutput("irq_released", 32'(irq_L), 32'h1);
        @(negedge clk); sprOvf_set = 1'b1; sprColl_set = 1'b1;
        @(negedge clk); sprOvf_set = 1'b0; sprColl_set = 1'b0;
        applyStimulus(1'b0, 1'b1, 8'h00);
        checkOutput("status_spr_flags", 32'(cpu_data_out), 32'h60);

        // A control read clears a half-finished control write
        applyStimulus(1'b1, 1'b1, 8'h11);
        applyStimulus(1'b0, 1'b1, 8'h00);
        applyStimulus(1'b1, 1'b1, 8'h22);
        applyStimulus(1'b1, 1'b1, 8'h81);
        @(negedge clk);
        checkOutput("first_done_cleared", 32'(regFile[15:8]), 32'h22);
        checkOutput("first_done_no_wait", 32'(cpu_wait), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL global_timeout: simulation still running at 200000, expected done");
        $fatal(1, "[TB] timeout");
    end

endmodule

// File: doc/vdp_cpu_port.md
Name: vdp_cpu_port

Overview:
- CPU-side write/read front end of the VDP. It decodes Z80 accesses on the VDP data and control ports.
- It writes VRAM, CRAM and the VDP register file, which the display pipeline then reads.
- It services CPU VRAM reads through a one-byte read-ahead buffer and returns the status byte.
- VRAM/CRAM accesses are deferred while the display pipeline holds screenBusy.

Parameters:
- RD_LAT, 2, clock cycles from VRAM_rd_en to valid VRAM_rd_data.
- NUM_REGS, 10, number of implemented VDP registers.

Ports:
- clk  input  1  system clock
- rst_L  input  1  synchronous active-low reset
- cpu_wr  input  1  one-cycle CPU write strobe
- cpu_rd  input  1  one-cycle CPU read strobe
- cpu_port_sel  input  1  0 = data port, 1 = control port
- cpu_data_in  input  8  CPU write data
- cpu_data_out  output  8  CPU read data, held until the next read
- cpu_wait  output  1  access in progress; CPU must not strobe
- screenBusy  input  1  display pipeline owns VRAM/CRAM
- VRAM_addr  output  14  VRAM byte address
- VRAM_wr_en  output  1  one-cycle VRAM write
- VRAM_wr_data  output  8  VRAM write data
- VRAM_rd_en  output  1  one-cycle VRAM read request
- VRAM_rd_data  input  8  VRAM read data
- CRAM_wr_en  output  1  one-cycle CRAM write
- CRAM_addr  output  5  CRAM entry
- CRAM_wr_data  output  6  colour, format BBGGRR
- regFile  output  NUM_REGS×8  VDP registers
- frame_set, sprOvf_set, sprColl_set  input  1 each  status flag set pulses
- irq_L  output  1  active-low frame interrupt

Behaviour:

Reset (rst_L=0 at a clk edge):
- All outputs 0, except irq_L=1.
- addr=0, code=0, firstByte flag clear, read buffer=0, status=0, regFile all 0.
- FSM goes to IDLE; any pending access is aborted.

Internal state:
- addr[13:0], code[1:0], latch[7:0], firstDone, rdBuf[7:0], status[7:5].

Control write:
- If firstDone=0: latch<=data, addr[7:0]<=data, firstDone<=1.
- If firstDone=1: code<=data[7:6], addr[13:8]<=data[5:0], firstDone<=0. Then, by code:
  - code=10: regFile[data[3:0]]<=latch when the index < NUM_REGS; otherwise ignored. No memory access.
  - code=00: start a prefetch read of VRAM[addr]; rdBuf<=result; addr++.

Data write:
- firstDone<=0.
- code=11: CRAM write, CRAM_addr=addr[4:0], CRAM_wr_data=data[5:0].
- Otherwise: VRAM write at addr with data.
- In both cases rdBuf<=data and addr++.

Data read:
- firstDone<=0.
- cpu_data_out<=rdBuf in the strobe cycle+1.
- Then start a refill read of VRAM[addr], rdBuf<=result, addr++.

Control read:
- cpu_data_out<={status[7:5],5'b0}; status<=0; firstDone<=0.
- Never stalls.

Address arithmetic:
- addr increments modulo 2^14 (3FFF→0000). CRAM uses addr[4:0] only (1F→00).

Status register:
- A set pulse in the same cycle as a control-read clear leaves that bit set (set wins).
- irq_L = ~(status[7] & regFile[1][5]), registered.

FSM, states IDLE, WAIT_BUS, WRITE, RD_ISSUE, RD_WAIT:
- IDLE → WAIT_BUS on a strobe that needs VRAM/CRAM.
- WAIT_BUS → WRITE or RD_ISSUE in the first cycle screenBusy=0; stays in WAIT_BUS while screenBusy=1.
- WRITE: exactly one cycle of VRAM_wr_en or CRAM_wr_en → IDLE.
- RD_ISSUE: one cycle of VRAM_rd_en → RD_WAIT.
- RD_WAIT: counts RD_LAT cycles, captures VRAM_rd_data into rdBuf, → IDLE.
- addr increments on the cycle the access is performed (WRITE or data capture).
- The memory address and data bus are snapshotted at the strobe, so the increment does not disturb the access in flight.

cpu_wait:
- High in every non-IDLE state, i.e. from strobe+1 until back in IDLE.
- A strobe while cpu_wait=1 is a protocol violation and is ignored (no state change).
- Register writes, status reads and first control bytes complete in the strobe cycle; cpu_wait stays 0.

Minimum latencies with screenBusy=0:
- Write: write enable at strobe+2.
- Read refill: rdBuf valid at strobe+3+RD_LAT.

Test Plan:
- Control writes 0x34, 0x52 (code 01), then data write 0xAB with screenBusy=0 → VRAM_wr_en one cycle with VRAM_addr=0x1234, VRAM_wr_data=0xAB; addr becomes 0x1235; cpu_wait high exactly 2 cycles.
- Control writes 0x07, 0x81 → regFile[1]=0x07, no VRAM/CRAM enables, cpu_wait stays 0. Control writes 0x55, 0x8C (index 12) → regFile unchanged.
- Control writes 0xFF, 0x3F (code 00, addr 0x3FFF) with VRAM returning 0x11 → prefetch reads 0x3FFF, rdBuf=0x11, addr wraps to 0x0000; next data read returns 0x11 and a refill read is issued at 0x0000.
- Control writes 0x1F, 0xC0 (CRAM); data writes 0x3C then 0x03 → CRAM[31]=0x3C, CRAM[0]=0x03 (5-bit wrap).
- Data write requested with screenBusy=1 for 20 cycles → no write enable and cpu_wait=1 throughout; write enable in the cycle after screenBusy falls.
- frame_set pulse with regFile[1][5]=1 → irq_L=0. A control read coincident with a second frame_set pulse → cpu_data_out=0x80 and status[7] stays set. A control write of only one byte followed by a control read → firstDone cleared.
